fl_vadd_ddr_writer: RTL and testbench



---
 rtl/fl_vadd_ddr_writer_if.sv | 35 +++
 rtl/fl_vadd_ddr_writer.sv | 145 ++++++++++++++
 tb/tb_fl_vadd_ddr_writer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fl_vadd_ddr_writer_if.sv
// Stream-in / AXI-Lite-write bundle for the vector-add DDR writer.
//   Stream : in_data, in_valid, in_ready, in_tlast (one sum element per beat)
//   AW     : waddr, wavalid, waready
//   W      : wdata, wvalid, wready
//   B      : wresp (1 = error), bvalid, bready
// master : the writer (consumes the stream, drives the AXI-Lite write side)
// slave  : the environment (stream source plus DDR write slave)
interface fl_vadd_ddr_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_tlast;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wavalid;
  logic                  waready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  in_data, in_valid, in_tlast, waready, wready, wresp, bvalid,
    output in_ready, waddr, wavalid, wdata, wvalid, bready
  );

  modport slave (
    output in_data, in_valid, in_tlast, waready, wready, wresp, bvalid,
    input  in_ready, waddr, wavalid, wdata, wvalid, bready
  );
endinterface

// File: rtl/fl_vadd_ddr_writer.sv
// Vector-add DDR writer: takes the sum stream one element at a time and
// writes each element to DDR as a single-beat AXI-Lite write. Addresses
// start at base_addr and step by one data word, wrapping modulo the DDR
// address space.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, base_addr  job start pulse and first write address (from PS regs)
//   bus               stream input + AXI-Lite write master (master modport)
//   busy              job in progress
//   done              one-cycle pulse at job end
//   err               sticky: some B response in this job reported an error
//   beat_count        B responses received in the current/last job (saturating)
module fl_vadd_ddr_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DDR_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(DDR_DEPTH),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  fl_vadd_ddr_writer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_ISSUE, S_RESP, S_FIN
  } state_t;

  // Element captured on stream acceptance; drives AW/W until both complete.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } beat_t;

  state_t                state, state_nxt;
  beat_t                 beat;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  aw_done, w_done;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic accept, aw_hs, w_hs, b_hs, job_start;

  assign job_start = (state == S_IDLE) && start;
  assign accept    = (state == S_WAIT_DATA) && bus.in_valid;
  assign aw_hs     = bus.wavalid && bus.waready;
  assign w_hs      = bus.wvalid && bus.wready;
  assign b_hs      = (state == S_RESP) && bus.bvalid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (bus.in_valid) state_nxt = S_ISSUE;
      // A channel counts as complete if it finished earlier or finishes now.
      S_ISSUE:     if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_RESP;
      S_RESP:      if (bus.bvalid) state_nxt = beat.last ? S_FIN : S_WAIT_DATA;
      S_FIN:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE, so every valid drops at once.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.wavalid  = 1'b0;
    bus.wvalid   = 1'b0;
    bus.bready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      S_WAIT_DATA: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      S_ISSUE: begin
        bus.wavalid = ~aw_done;
        bus.wvalid  = ~w_done;
        busy        = 1'b1;
      end
      S_RESP: begin
        bus.bready = 1'b1;
        busy       = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address walk, captured beat, per-channel done flags, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      beat     <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (job_start) begin
        cur_addr <= base_addr;
        err_q    <= 1'b0;
        cnt_q    <= '0;
      end
      if (accept) begin
        beat.data <= bus.in_data;
        beat.addr <= cur_addr;
        beat.last <= bus.in_tlast;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (state == S_ISSUE) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        err_q <= err_q | bus.wresp;
        // Address wraps naturally at the register width.
        if (!beat.last) cur_addr <= cur_addr + ADDR_STEP;
      end
    end
  end

  assign bus.waddr  = beat.addr;
  assign bus.wdata  = beat.data;
  assign err        = err_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_fl_vadd_ddr_writer.sv
module tb_fl_vadd_ddr_writer;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err;
  logic [CW-1:0] beat_count;

  fl_vadd_ddr_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fl_vadd_ddr_writer #(.DATA_WIDTH(DW), .DDR_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: expected AW addresses and W data, pushed when a beat is driven.
  logic [AW-1:0] exp_aw[$];
  logic [DW-1:0] exp_w[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DDR slave model
  int          aw_dly = 0, w_dly = 0;
  logic [7:0]  resp_mask = '0;
  int          b_total = 0, b_base = 0;

  initial begin
    int aw_cnt, w_cnt, bi;
    aw_cnt = 0; w_cnt = 0;
    bus.waready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.wresp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.wavalid) begin bus.waready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin bus.waready = 1'b0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= w_dly); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      bus.bvalid = bus.bready;
      bi = b_total - b_base;
      bus.wresp = resp_mask[bi[2:0]];
    end
  end

  // Monitor, sampled on the falling edge
  int            aw_hs = 0, w_hs = 0, acc_cyc = 0;
  logic          aw_hold_v = 1'b0, w_hold_v = 1'b0;
  logic [AW-1:0] aw_hold;
  logic [DW-1:0] w_hold;

  always @(negedge clk) begin
    if (rst) begin
      aw_hold_v = 1'b0;
      w_hold_v  = 1'b0;
    end else begin
      if (bus.wavalid) begin
        if (aw_hold_v) chk("waddr_stable", 32'(bus.waddr), 32'(aw_hold));
        if (bus.waready) begin
          aw_hs++;
          chk("aw_expected", 32'(exp_aw.size() != 0), 1);
          if (exp_aw.size() != 0) chk("waddr", 32'(bus.waddr), 32'(exp_aw.pop_front()));
          aw_hold_v = 1'b0;
        end else begin
          aw_hold_v = 1'b1;
          aw_hold   = bus.waddr;
        end
      end else aw_hold_v = 1'b0;
      if (bus.wvalid) begin
        if (w_hold_v) chk("wdata_stable", bus.wdata, w_hold);
        if (bus.wready) begin
          w_hs++;
          chk("w_expected", 32'(exp_w.size() != 0), 1);
          if (exp_w.size() != 0) chk("wdata", bus.wdata, exp_w.pop_front());
          w_hold_v = 1'b0;
        end else begin
          w_hold_v = 1'b1;
          w_hold   = bus.wdata;
        end
      end else w_hold_v = 1'b0;
      if (bus.bvalid && bus.bready) b_total++;
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    logic [31:0]   seed;
    logic [7:0]    mask;
    int            aw_dly;
    int            w_dly;
    bit            restart;
    bit            exp_err;
    int            exp_cnt;
  } vec_t;

  vec_t vt[8];

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input logic [AW-1:0] a);
    int t;
    exp_aw.push_back(a);
    exp_w.push_back(d);
    bus.in_data  = d;
    bus.in_tlast = last;
    bus.in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 200);
    chk("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_tlast = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int aw0, w0, t;
    logic [AW-1:0] a;
    aw_dly = v.aw_dly; w_dly = v.w_dly; resp_mask = v.mask;
    b_base = b_total; aw0 = aw_hs; w0 = w_hs;
    @(posedge clk); #1;
    base_addr = v.base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_s1"}, busy, 1);
    chk({tag, "_in_ready_s1"}, bus.in_ready, 1);
    chk({tag, "_err_clr"}, err, 0);
    chk({tag, "_cnt_clr"}, 32'(beat_count), 0);
    if (v.restart) begin
      base_addr = v.base ^ 5'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_restart"}, busy, 1);
    end
    for (int i = 0; i < v.n; i++) begin
      a = v.base + AW'(4 * i);
      send_beat(v.seed + 32'(i), (i == v.n - 1), a);
    end
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt_at_done"}, 32'(beat_count), 32'(v.exp_cnt));
    chk({tag, "_err_at_done"}, err, v.exp_err);
    if (v.aw_dly == 0 && v.w_dly == 0) chk({tag, "_done_latency"}, cyc - acc_cyc, 3);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_err_sticky"}, err, v.exp_err);
    chk({tag, "_cnt_after"}, 32'(beat_count), 32'(v.exp_cnt));
    chk({tag, "_aw_hs"}, aw_hs - aw0, v.n);
    chk({tag, "_w_hs"}, w_hs - w0, v.n);
    chk({tag, "_sb_empty"}, exp_aw.size() + exp_w.size(), 0);
  endtask

  initial begin
    int t;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_tlast = 1'b0;
    //        base   n  seed      mask    awd wd rs err cnt
    vt[0] = '{5'h00, 4, 32'h1,    8'h00,  0,  0, 0, 0,  4};
    vt[1] = '{5'h04, 3, 32'h100,  8'h00,  3,  0, 0, 0,  3};
    vt[2] = '{5'h08, 3, 32'h200,  8'h00,  0,  3, 0, 0,  3};
    vt[3] = '{5'h18, 3, 32'h300,  8'h00,  0,  0, 0, 0,  3};
    vt[4] = '{5'h00, 3, 32'h400,  8'h02,  0,  0, 0, 1,  3};
    vt[5] = '{5'h1C, 2, 32'h500,  8'h00,  2,  1, 0, 0,  2};
    vt[6] = '{5'h00, 2, 32'h600,  8'h00,  0,  0, 1, 0,  2};
    vt[7] = '{5'h0C, 1, 32'h700,  8'h00,  0,  0, 0, 0,  1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wavalid", bus.wavalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_waddr", 32'(bus.waddr), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_cnt", 32'(beat_count), 0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_job(vt[k], $sformatf("job%0d", k));

    // Reset while AW is held off by the slave
    aw_dly = 5; w_dly = 0; resp_mask = '0; b_base = b_total;
    @(posedge clk); #1;
    base_addr = 5'h08; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_aw.push_back(5'h08);
    exp_w.push_back(32'h55);
    bus.in_data = 32'h55; bus.in_tlast = 1'b0; bus.in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 50);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_wavalid_pre", bus.wavalid, 1);
    chk("mid_wvalid_pre", bus.wvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wavalid", bus.wavalid, 0);
    chk("mid_rst_wvalid", bus.wvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_waddr", 32'(bus.waddr), 0);
    chk("mid_rst_cnt", 32'(beat_count), 0);
    repeat (2) @(posedge clk);
    exp_aw.delete();
    exp_w.delete();
    #1 rst = 1'b0;
    run_job(vt[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
